// File: rtl/tile_ram_arbiter_pkg.sv
// Shared video constants and arbiter FSM encoding for the tile RAM path.
package tile_ram_arbiter_pkg;

  localparam int unsigned SCREEN_W      = 640;
  localparam int unsigned SCREEN_H      = 480;
  localparam int unsigned TILE_SHIFT    = 5;
  localparam int unsigned TILE_SIZE     = 32;
  localparam int unsigned TILE_Y0_DEF   = 100;
  localparam int unsigned TILE_COLS_DEF = 20;
  localparam int unsigned TILE_ROWS_DEF = 10;
  localparam int unsigned LOOKAHEAD_DEF = 8;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DISP_WAIT   = 2'd1,
    CPU_RD_WAIT = 2'd2,
    CPU_ACK     = 2'd3
  } arb_state_t;

endpackage

// File: rtl/tile_ram_arbiter_if.sv
// Game-logic access bus into the tile RAM arbiter.
interface tile_ram_arbiter_if;
  logic       cpu_req;
  logic       cpu_we;
  logic [7:0] cpu_addr;
  logic [3:0] cpu_wdata;
  logic       cpu_ack;
  logic [3:0] cpu_rdata;

  modport master (output cpu_req, cpu_we, cpu_addr, cpu_wdata,
                  input  cpu_ack, cpu_rdata);
  modport slave  (input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
                  output cpu_ack, cpu_rdata);
endinterface

// File: rtl/tile_ram_arbiter_tile_index_calc.sv
// Maps a pixel position to its tile index and flags whether it lies in the tile area.
module tile_index_calc
  import tile_ram_arbiter_pkg::*;
#(
  parameter int unsigned TILE_Y0   = TILE_Y0_DEF,
  parameter int unsigned TILE_COLS = TILE_COLS_DEF,
  parameter int unsigned TILE_ROWS = TILE_ROWS_DEF
) (
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [7:0] idx,
  output logic       in_area
);

  logic [9:0] dy;
  logic [4:0] row;
  logic [4:0] col;

  // Row/column split of the 32x32 grid; idx is only meaningful when in_area is set.
  always_comb begin
    dy      = y - 10'(TILE_Y0);
    row     = 5'(dy >> TILE_SHIFT);
    col     = 5'(x >> TILE_SHIFT);
    in_area = (y >= 10'(TILE_Y0)) &&
              (y <  10'(TILE_Y0 + TILE_ROWS * TILE_SIZE)) &&
              (x <  10'(TILE_COLS * TILE_SIZE));
    idx     = 8'(row) * 8'(TILE_COLS) + 8'(col);
  end

endmodule

// File: rtl/tile_ram_arbiter.sv
// Shares one single-port tile RAM between display prefetch and game-logic access.
module tile_ram_arbiter
  import tile_ram_arbiter_pkg::*;
#(
  parameter int unsigned LOOKAHEAD = LOOKAHEAD_DEF,
  parameter int unsigned TILE_Y0   = TILE_Y0_DEF,
  parameter int unsigned TILE_COLS = TILE_COLS_DEF,
  parameter int unsigned TILE_ROWS = TILE_ROWS_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [9:0]               pixel_x,
  input  logic [9:0]               pixel_y,
  input  logic                     vid_on,
  tile_ram_arbiter_if.slave        cpu,
  output logic [7:0]               ram_addr,
  output logic                     ram_we,
  output logic [3:0]               ram_wdata,
  input  logic [3:0]               ram_rdata,
  output logic [3:0]               tile_data,
  output logic                     tile_valid
);

  arb_state_t state, state_nxt;

  logic [10:0] la_sum;
  logic [9:0]  la_x, la_y;
  logic [7:0]  la_idx, cur_idx;
  logic        la_in_area, cur_in_area;
  logic [7:0]  next_idx, ram_addr_q;
  logic [3:0]  next_tile, ram_wdata_q, cpu_rdata_q;
  logic        next_valid, accept_dis, disp_need, cpu_oob, wr_grant;

  // Lookahead point; running past the right edge continues on the next row.
  always_comb begin
    la_sum = {1'b0, pixel_x} + 11'(LOOKAHEAD);
    if (la_sum >= 11'(SCREEN_W)) begin
      la_x = 10'(la_sum - 11'(SCREEN_W));
      la_y = pixel_y + 10'd1;
    end else begin
      la_x = la_sum[9:0];
      la_y = pixel_y;
    end
  end

  tile_index_calc #(.TILE_Y0(TILE_Y0), .TILE_COLS(TILE_COLS), .TILE_ROWS(TILE_ROWS))
    u_cur_idx (.x(pixel_x), .y(pixel_y), .idx(cur_idx), .in_area(cur_in_area));

  tile_index_calc #(.TILE_Y0(TILE_Y0), .TILE_COLS(TILE_COLS), .TILE_ROWS(TILE_ROWS))
    u_la_idx (.x(la_x), .y(la_y), .idx(la_idx), .in_area(la_in_area));

  assign disp_need     = la_in_area && (!next_valid || (la_idx != next_idx));
  assign cpu_oob       = cpu.cpu_addr >= 8'(TILE_COLS * TILE_ROWS);
  assign cpu.cpu_ack   = (state == CPU_ACK);
  assign cpu.cpu_rdata = cpu_rdata_q;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Grant decode; RAM address/data are driven in the grant cycle and held afterwards.
  // Grants are masked by rst_n because the grant-cycle outputs are combinational.
  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    ram_addr  = ram_addr_q;
    ram_wdata = ram_wdata_q;
    wr_grant  = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n) begin
          if (disp_need) begin
            ram_addr  = la_idx;
            state_nxt = DISP_WAIT;
          end else if (cpu.cpu_req && !accept_dis) begin
            if (cpu.cpu_we) begin
              state_nxt = CPU_ACK;
              if (!cpu_oob) begin
                ram_we    = 1'b1;
                ram_addr  = cpu.cpu_addr;
                ram_wdata = cpu.cpu_wdata;
                wr_grant  = 1'b1;
              end
            end else begin
              state_nxt = CPU_RD_WAIT;
              if (!cpu_oob) ram_addr = cpu.cpu_addr;
            end
          end
        end
      end
      DISP_WAIT:   state_nxt = IDLE;
      CPU_RD_WAIT: state_nxt = CPU_ACK;
      CPU_ACK:     state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  // Prefetch buffer, CPU read data and held RAM bus; ram_addr_q doubles as the fetched index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      next_idx    <= '0;
      next_tile   <= '0;
      next_valid  <= 1'b0;
      accept_dis  <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      ram_addr_q  <= ram_addr;
      ram_wdata_q <= ram_wdata;
      accept_dis  <= (state == CPU_ACK);
      if (state == DISP_WAIT) begin
        next_tile  <= ram_rdata;
        next_idx   <= ram_addr_q;
        next_valid <= 1'b1;
      end else if (wr_grant && (cpu.cpu_addr == next_idx)) begin
        next_valid <= 1'b0;
      end
      if (state == CPU_RD_WAIT) cpu_rdata_q <= cpu_oob ? '0 : ram_rdata;
    end
  end

  // Promote the prefetched tile once the scan reaches it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_data  <= '0;
      tile_valid <= 1'b0;
    end else if (!vid_on || !cur_in_area) begin
      tile_valid <= 1'b0;
    end else if (next_valid && (cur_idx == next_idx)) begin
      tile_data  <= next_tile;
      tile_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tile_ram_arbiter.sv
// Directed bench for tile_ram_arbiter with a 1-cycle-latency RAM model.
module tb_tile_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] pixel_x, pixel_y;
  logic       vid_on;
  logic [7:0] ram_addr;
  logic       ram_we;
  logic [3:0] ram_wdata, ram_rdata;
  logic [3:0] tile_data;
  logic       tile_valid;

  int checks = 0;
  int errors = 0;

  logic [3:0] mem [256];
  logic       mem_loaded = 1'b0;

  tile_ram_arbiter_if cpu_if ();

  tile_ram_arbiter #(.LOOKAHEAD(8), .TILE_Y0(100), .TILE_COLS(20), .TILE_ROWS(10)) dut (
    .clk(clk), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y), .vid_on(vid_on),
    .cpu(cpu_if), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .tile_data(tile_data), .tile_valid(tile_valid)
  );

  always #5 clk = ~clk;

  // RAM model: contents start as mem[i] = i+1 (mod 16).
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 4'(i + 1);
      mem_loaded <= 1'b1;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with a write request pending and a display need present
    rst_n = 1'b0; vid_on = 1'b1; pixel_x = 10'd0; pixel_y = 10'd100;
    cpu_if.cpu_req = 1'b1; cpu_if.cpu_we = 1'b1; cpu_if.cpu_addr = 8'd5; cpu_if.cpu_wdata = 4'h3;
    tick(); tick();
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_cpu_ack", cpu_if.cpu_ack, 0);
    chk("rst_cpu_rdata", cpu_if.cpu_rdata, 0);
    chk("rst_tile_valid", tile_valid, 0);
    chk("rst_tile_data", tile_data, 0);
    cpu_if.cpu_req = 1'b0; pixel_y = 10'd0; vid_on = 1'b0;
    rst_n = 1'b1;
    tick();

    // Write addr 5 = 3
    cpu_if.cpu_req = 1'b1; cpu_if.cpu_we = 1'b1; cpu_if.cpu_addr = 8'd5; cpu_if.cpu_wdata = 4'h3;
    #1;
    chk("wr_ram_we", ram_we, 1);
    chk("wr_ram_addr", ram_addr, 5);
    chk("wr_ram_wdata", ram_wdata, 3);
    chk("wr_ack_early", cpu_if.cpu_ack, 0);
    tick();
    chk("wr_ack", cpu_if.cpu_ack, 1);
    chk("wr_we_drop", ram_we, 0);
    chk("wr_addr_hold", ram_addr, 5);
    tick();
    // Request still high in the cycle after ack: must not be re-served
    chk("wr_no_double", ram_we, 0);
    cpu_if.cpu_req = 1'b0;
    tick();
    chk("wr_no_double_ack", cpu_if.cpu_ack, 0);

    // Read addr 5
    cpu_if.cpu_req = 1'b1; cpu_if.cpu_we = 1'b0; cpu_if.cpu_addr = 8'd5;
    #1;
    chk("rd_ram_addr", ram_addr, 5);
    chk("rd_ram_we", ram_we, 0);
    tick();
    chk("rd_ack_early", cpu_if.cpu_ack, 0);
    tick();
    chk("rd_ack", cpu_if.cpu_ack, 1);
    chk("rd_data", cpu_if.cpu_rdata, 3);
    cpu_if.cpu_req = 1'b0;
    tick();
    chk("rd_ack_once", cpu_if.cpu_ack, 0);
    tick();

    // Out-of-range write and read
    cpu_if.cpu_req = 1'b1; cpu_if.cpu_we = 1'b1; cpu_if.cpu_addr = 8'd250; cpu_if.cpu_wdata = 4'hF;
    #1;
    chk("oob_wr_we", ram_we, 0);
    tick();
    chk("oob_wr_ack", cpu_if.cpu_ack, 1);
    cpu_if.cpu_req = 1'b0;
    tick(); tick();
    cpu_if.cpu_req = 1'b1; cpu_if.cpu_we = 1'b0; cpu_if.cpu_addr = 8'd250;
    tick(); tick();
    chk("oob_rd_ack", cpu_if.cpu_ack, 1);
    chk("oob_rd_data", cpu_if.cpu_rdata, 0);
    cpu_if.cpu_req = 1'b0;
    tick(); tick();

    // Scan row y=100 across tiles 0 and 1 after an initial prefetch
    pixel_y = 10'd100; pixel_x = 10'd0; vid_on = 1'b0;
    tick(); tick(); tick();
    chk("scan_blank_valid", tile_valid, 0);
    for (int x = 0; x < 64; x++) begin
      pixel_x = 10'(x); vid_on = 1'b1;
      tick();
      chk("scan_tile_data", tile_data, (x < 32) ? 16'd1 : 16'd2);
      chk("scan_tile_valid", tile_valid, 1);
    end
    vid_on = 1'b0;
    tick();
    chk("vid_off_valid", tile_valid, 0);

    // Display need and CPU read in the same cycle: display first
    pixel_x = 10'd88;
    cpu_if.cpu_req = 1'b1; cpu_if.cpu_we = 1'b0; cpu_if.cpu_addr = 8'd5;
    #1;
    chk("pri_disp_addr", ram_addr, 3);
    tick();
    chk("pri_ack_c1", cpu_if.cpu_ack, 0);
    tick();
    chk("pri_cpu_addr", ram_addr, 5);
    tick(); tick();
    chk("pri_ack_c4", cpu_if.cpu_ack, 1);
    chk("pri_rdata", cpu_if.cpu_rdata, 3);
    cpu_if.cpu_req = 1'b0; pixel_x = 10'd96; vid_on = 1'b1;
    tick();
    chk("pri_tile_data", tile_data, 4);
    chk("pri_tile_valid", tile_valid, 1);
    tick();

    // Write to the prefetched index forces a refetch
    cpu_if.cpu_req = 1'b1; cpu_if.cpu_we = 1'b1; cpu_if.cpu_addr = 8'd3; cpu_if.cpu_wdata = 4'h9;
    #1;
    chk("inv_wr_we", ram_we, 1);
    tick();
    cpu_if.cpu_req = 1'b0;
    tick();
    chk("inv_refetch_addr", ram_addr, 3);
    chk("inv_refetch_we", ram_we, 0);
    tick(); tick(); tick();
    chk("inv_tile_data", tile_data, 9);

    // Lookahead wrap from the end of row 131 to tile 20
    pixel_x = 10'd639; pixel_y = 10'd131;
    #1;
    chk("wrap_prefetch_addr", ram_addr, 20);
    tick(); tick();
    pixel_x = 10'd0; pixel_y = 10'd132;
    tick();
    chk("wrap_tile_data", tile_data, 5);
    chk("wrap_tile_valid", tile_valid, 1);

    // Reset during CPU_RD_WAIT abandons the access; reissue completes
    pixel_y = 10'd0;
    cpu_if.cpu_req = 1'b1; cpu_if.cpu_we = 1'b0; cpu_if.cpu_addr = 8'd5;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", cpu_if.cpu_ack, 0);
    chk("mid_rst_rdata", cpu_if.cpu_rdata, 0);
    chk("mid_rst_we", ram_we, 0);
    chk("mid_rst_addr", ram_addr, 0);
    chk("mid_rst_tile", tile_data, 0);
    tick();
    chk("mid_rst_ack_hold", cpu_if.cpu_ack, 0);
    rst_n = 1'b1;
    #1;
    chk("reissue_addr", ram_addr, 5);
    tick(); tick();
    chk("reissue_ack", cpu_if.cpu_ack, 1);
    chk("reissue_rdata", cpu_if.cpu_rdata, 3);
    cpu_if.cpu_req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
